// File: rtl/dpr_pkg.sv
// Shared types, constants and helpers for the dpr_be dual-port RAM.
package dpr_pkg;

  // Initialisation sequencer states: sweeping the array, or serving ports.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Read-during-write result selection for a same-address collision.
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Byte-lane merge: take the new byte when its enable is set, else keep the old one.
  // Applied lane by lane for both the array write and the write-through bypass,
  // so both paths always agree on what a partial write produces.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/dpr_init_seq.sv
// Zero-initialisation sequencer: sweeps every word after reset and on a clr request.
module dpr_init_seq
  import dpr_pkg::*;
#(
  parameter int ADD_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic             busy,
  output logic             sweep_we,
  output logic [ADD_W-1:0] sweep_add
);

  state_t           state;
  logic [ADD_W-1:0] cnt;

  // Sweep FSM: one zero write per cycle; the all-ones terminal compare ends the
  // sweep, so the counter never wraps back into address 0 while still clearing.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (&cnt) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign sweep_we  = (state == CLEAR);
  assign sweep_add = cnt;

endmodule

// File: rtl/dpr_be.sv
// Simple dual-port RAM: byte-enabled write port A, read port B with 1 or 2
// cycles of latency, selectable read-during-write result, and a built-in
// zero sweep after reset or on clr.
module dpr_be
  import dpr_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADD_W    = 4,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADD_W-1:0]    a_add,
  input  logic [DATA_W-1:0]   a_din,
  input  logic                b_re,
  input  logic [ADD_W-1:0]    b_add,
  output logic [DATA_W-1:0]   b_dout,
  output logic                b_valid,
  input  logic                clr,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADD_W;

  logic             sweep_we;
  logic [ADD_W-1:0] sweep_add;

  dpr_init_seq #(.ADD_W(ADD_W)) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .busy      (busy),
    .sweep_we  (sweep_we),
    .sweep_add (sweep_add)
  );

  // Port strobes are only honoured once the sweep has finished.
  logic wr_en;
  logic rd_en;
  assign wr_en = a_we & ~busy;
  assign rd_en = b_re & ~busy;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] old_a;
  logic [DATA_W-1:0] old_b;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_word;
  logic              collide;

  assign old_a = mem[a_add];
  assign old_b = mem[b_add];

  // Merged write word: enabled lanes from a_din, the rest from the stored word.
  always_comb begin
    wr_word = old_a;
    for (int i = 0; i < BE_W; i++) begin
      wr_word[8*i +: 8] = merge_byte(old_a[8*i +: 8], a_din[8*i +: 8], a_be[i]);
    end
  end

  // Same-address collision forwards the merged word only in write-through mode.
  assign collide = wr_en & (a_add == b_add);
  assign rd_word = ((RDW_MODE == RDW_NEW) && collide) ? wr_word : old_b;

  // Array write port: sweep zeros take priority (port A is gated off while busy anyway).
  // NOTE: the storage array has no reset; the sweep sequencer is what zeroes it.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_add] <= '0;
    end else if (wr_en) begin
      mem[a_add] <= wr_word;
    end
  end

  logic              rd_valid1;
  logic [DATA_W-1:0] rd_data1;

  // First read stage: capture on an accepted read, otherwise hold the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid1 <= 1'b0;
      rd_data1  <= '0;
    end else begin
      rd_valid1 <= rd_en;
      if (rd_en) begin
        rd_data1 <= rd_word;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              rd_valid2;
      logic [DATA_W-1:0] rd_data2;

      // Optional output register stage for timing-critical consumers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_valid2 <= 1'b0;
          rd_data2  <= '0;
        end else begin
          rd_valid2 <= rd_valid1;
          if (rd_valid1) begin
            rd_data2 <= rd_data1;
          end
        end
      end

      assign b_dout  = rd_data2;
      assign b_valid = rd_valid2;
    end else begin : g_lat1
      assign b_dout  = rd_data1;
      assign b_valid = rd_valid1;
    end
  endgenerate

endmodule

// File: tb/tb_dpr_be.sv
// Scoreboard bench for dpr_be: three instances (RD_LAT/RDW_MODE = 1/0, 1/1, 2/0)
// share one stimulus stream; each has its own expected-response queue.
module tb_dpr_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_we;
  logic [1:0]  a_be;
  logic [3:0]  a_add;
  logic [15:0] a_din;
  logic        b_re;
  logic [3:0]  b_add;
  logic        clr;

  logic [15:0] dout0, dout1, dout2;
  logic        valid0, valid1, valid2;
  logic        busy0, busy1, busy2;

  always #5 clk = ~clk;

  dpr_be #(.DATA_W(16), .ADD_W(4), .RD_LAT(1), .RDW_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .a_we(a_we), .a_be(a_be), .a_add(a_add), .a_din(a_din),
    .b_re(b_re), .b_add(b_add), .b_dout(dout0), .b_valid(valid0), .clr(clr), .busy(busy0));

  dpr_be #(.DATA_W(16), .ADD_W(4), .RD_LAT(1), .RDW_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a_we(a_we), .a_be(a_be), .a_add(a_add), .a_din(a_din),
    .b_re(b_re), .b_add(b_add), .b_dout(dout1), .b_valid(valid1), .clr(clr), .busy(busy1));

  dpr_be #(.DATA_W(16), .ADD_W(4), .RD_LAT(2), .RDW_MODE(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .a_we(a_we), .a_be(a_be), .a_add(a_add), .a_din(a_din),
    .b_re(b_re), .b_add(b_add), .b_dout(dout2), .b_valid(valid2), .clr(clr), .busy(busy2));

  typedef struct {
    logic [15:0] data;
    int          due;
  } sb_t;

  sb_t q0[$];
  sb_t q1[$];
  sb_t q2[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int lat [3] = '{1, 1, 2};

  logic [2:0]  busy_v;
  logic [2:0]  valid_v;
  logic [15:0] dout_v [3];
  assign busy_v    = {busy2, busy1, busy0};
  assign valid_v   = {valid2, valid1, valid0};
  assign dout_v[0] = dout0;
  assign dout_v[1] = dout1;
  assign dout_v[2] = dout2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic sb_t q_pop(input int id);
    case (id)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic int q_due(input int id);
    case (id)
      0:       return q0[0].due;
      1:       return q1[0].due;
      default: return q2[0].due;
    endcase
  endfunction

  task automatic push(input int id, input logic [15:0] data);
    sb_t e;
    e.data = data;
    e.due  = cyc + lat[id];
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Monitor: every b_valid pops and checks data and arrival cycle; an overdue
  // entry without b_valid is reported as missing.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (valid_v[i]) begin
          if (q_size(i) == 0) begin
            check($sformatf("dut%0d unexpected b_valid", i), 32'd1, 32'd0);
          end else begin
            sb_t e;
            e = q_pop(i);
            check($sformatf("dut%0d b_dout", i), {16'h0, dout_v[i]}, {16'h0, e.data});
            check($sformatf("dut%0d b_valid cycle", i), cyc, e.due);
          end
        end else if (q_size(i) > 0 && cyc > q_due(i)) begin
          sb_t e;
          e = q_pop(i);
          check($sformatf("dut%0d missing b_valid for %h", i, e.data), 32'd0, 32'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_we = 1'b0; a_be = 2'b00; a_add = '0; a_din = '0;
    b_re = 1'b0; b_add = '0; clr = 1'b0;
  endtask

  // One cycle of stimulus; acc says whether the read is expected to be accepted.
  task automatic op(input logic we, input logic [1:0] be, input logic [3:0] wa,
                    input logic [15:0] din, input logic re, input logic [3:0] ra,
                    input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                    input logic acc);
    a_we = we; a_be = be; a_add = wa; a_din = din;
    b_re = re; b_add = ra;
    if (re && acc) begin
      push(0, e0);
      push(1, e1);
      push(2, e2);
    end
    tick();
    idle();
  endtask

  task automatic wr(input logic [3:0] wa, input logic [15:0] din, input logic [1:0] be);
    op(1'b1, be, wa, din, 1'b0, 4'h0, 16'h0, 16'h0, 16'h0, 1'b1);
  endtask

  task automatic rd(input logic [3:0] ra, input logic [15:0] e);
    op(1'b0, 2'b00, 4'h0, 16'h0, 1'b1, ra, e, e, e, 1'b1);
  endtask

  // Counts edges until each instance drops busy; expects a full 16-cycle sweep.
  task automatic wait_sweep(input string tag);
    int d [3];
    d = '{-1, -1, -1};
    for (int k = 1; k <= 40; k++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        if (d[i] < 0 && !busy_v[i]) d[i] = k;
      end
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s dut%0d busy cycles", tag, i), d[i], 32'd16);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dut0 b_dout"}, {16'h0, dout0}, 32'h0);
    check({tag, " dut2 b_dout"}, {16'h0, dout2}, 32'h0);
    check({tag, " b_valid"}, {29'h0, valid_v}, 32'h0);
    check({tag, " busy"}, {29'h0, busy_v}, 32'h7);
  endtask

  initial begin
    int bc [3];
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_sweep("power-up");

    // Whole array reads back zero, one result per cycle.
    for (int a = 0; a < 16; a++) rd(4'(a), 16'h0000);
    repeat (3) tick();

    // Full, partial and empty byte-enable writes.
    wr(4'd5, 16'h1234, 2'b11);
    rd(4'd5, 16'h1234);
    wr(4'd5, 16'hABCD, 2'b01);
    rd(4'd5, 16'h12CD);
    wr(4'd5, 16'hFFFF, 2'b00);
    rd(4'd5, 16'h12CD);

    // Same-address collisions: old data vs. merged write-through.
    wr(4'd7, 16'h0040, 2'b11);
    op(1'b1, 2'b11, 4'd7, 16'h00FF, 1'b1, 4'd7, 16'h0040, 16'h00FF, 16'h0040, 1'b1);
    rd(4'd7, 16'h00FF);
    wr(4'd7, 16'h0040, 2'b11);
    op(1'b1, 2'b10, 4'd7, 16'hAA00, 1'b1, 4'd7, 16'h0040, 16'hAA40, 16'h0040, 1'b1);
    rd(4'd7, 16'hAA40);
    // Different addresses do not interact.
    op(1'b1, 2'b11, 4'd8, 16'h1111, 1'b1, 4'd7, 16'hAA40, 16'hAA40, 16'hAA40, 1'b1);
    rd(4'd8, 16'h1111);
    repeat (3) tick();

    // Clear during operation; strobes in the accepting cycle are still serviced.
    wr(4'd3, 16'h5555, 2'b11);
    rd(4'd3, 16'h5555);
    clr = 1'b1;
    op(1'b1, 2'b11, 4'd9, 16'h9999, 1'b1, 4'd3, 16'h5555, 16'h5555, 16'h5555, 1'b1);
    bc = '{0, 0, 0};
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 3; i++) bc[i] += int'(busy_v[i]);
      if (k == 2) begin
        a_we = 1'b1; a_be = 2'b11; a_add = 4'd3; a_din = 16'h7777;
        b_re = 1'b1; b_add = 4'd3;
      end
      if (k == 8) clr = 1'b1;
      tick();
      idle();
    end
    for (int i = 0; i < 3; i++) check($sformatf("clr dut%0d busy cycles", i), bc[i], 32'd16);
    rd(4'd3, 16'h0000);
    rd(4'd9, 16'h0000);
    rd(4'd7, 16'h0000);
    repeat (3) tick();

    // Asynchronous reset in the middle of a sweep.
    wr(4'd5, 16'hBEEF, 2'b11);
    rd(4'd5, 16'hBEEF);
    repeat (3) tick();
    clr = 1'b1;
    tick();
    idle();
    repeat (7) tick();
    check({"mid-sweep busy"}, {29'h0, busy_v}, 32'h7);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-sweep reset");
    tick();
    rst_n = 1'b1;
    wait_sweep("post-reset");
    rd(4'd5, 16'h0000);

    // Pipelined reads alternating two addresses.
    wr(4'd5, 16'h1234, 2'b11);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) rd(4'd5, 16'h1234);
      else            rd(4'd0, 16'h0000);
    end
    repeat (5) tick();

    for (int i = 0; i < 3; i++) check($sformatf("dut%0d scoreboard drained", i), q_size(i), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
